// File: rtl/write_back_buffer_pkg.sv
// Shared definitions for the write-back buffer: default line geometry and the
// push/pop operation encoding used to update the occupancy count.
package write_back_buffer_pkg;

    localparam int LINE_ASIZE = 12;
    localparam int LINE_DSIZE = 256;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } wbb_op_e;

endpackage

// File: rtl/write_back_buffer_if.sv
// Bus bundle between the cache/memory side (master) and the write-back buffer
// (slave): eviction handshake, refill lookup and memory drain port.
interface write_back_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 12,
    parameter int LW    = 256
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [LW-1:0] wb_data;
    logic          wb_ready;
    logic [AW-1:0] fetch_addr;
    logic [LW-1:0] fetch_data;
    logic [AW-1:0] mem_raddr;
    logic [LW-1:0] mem_read_data;
    logic          mem_wen;
    logic          mem_ready;
    logic [AW-1:0] mem_waddr;
    logic [LW-1:0] mem_wdata;
    logic [CW-1:0] count;

    modport master (
        output wb_valid, wb_addr, wb_data, fetch_addr, mem_read_data, mem_ready,
        input  wb_ready, fetch_data, mem_raddr, mem_wen, mem_waddr, mem_wdata, count
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, fetch_addr, mem_read_data, mem_ready,
        output wb_ready, fetch_data, mem_raddr, mem_wen, mem_waddr, mem_wdata, count
    );

endinterface

// File: rtl/write_back_buffer_match.sv
// DEPTH-way line address compare; among all valid matching entries the one
// closest to the tail (newest) wins.
module wbb_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [AW-1:0]            addr_i [DEPTH],
    input  logic [AW-1:0]            key_i,
    input  logic [$clog2(DEPTH)-1:0] newest_i,
    output logic                     hit_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] slot_s;

    // Walk oldest to newest so a later (newer) match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        slot_s = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            slot_s = newest_i - PW'(k);
            if (valid_i[slot_s] && (addr_i[slot_s] == key_i)) begin
                hit_o = 1'b1;
                idx_o = slot_s;
            end else begin
                hit_o = hit_o;
            end
        end
    end

endmodule

// File: rtl/write_back_buffer.sv
// Circular write-back buffer: coalesces evictions into pending non-head lines,
// drains the head to memory and forwards buffered lines to refills.
module write_back_buffer
    import write_back_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = LINE_ASIZE,
    parameter int LW    = LINE_DSIZE
) (
    input  logic               clk,
    input  logic               rst,
    write_back_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [LW-1:0]    data_q [DEPTH];

    logic             wb_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             alloc_s;
    logic [DEPTH-1:0] head_mask_s;
    logic [DEPTH-1:0] coal_valid_s;
    logic [PW-1:0]    newest_s;
    logic             coal_hit_s;
    logic [PW-1:0]    coal_idx_s;
    logic             fwd_hit_s;
    logic [PW-1:0]    fwd_idx_s;
    wbb_op_e          op_s;

    assign wb_ready_s   = (count_q < CW'(DEPTH));
    assign push_s       = bus.wb_valid && wb_ready_s;
    assign pop_s        = (count_q != CW'(0)) && bus.mem_ready;
    assign alloc_s      = push_s && !coal_hit_s;
    assign newest_s     = tail_q - PW'(1);
    assign coal_valid_s = valid_q & ~head_mask_s;
    assign op_s         = wbb_op_e'({alloc_s, pop_s});

    // One-hot of the head slot; the head may be draining so it never coalesces.
    always_comb begin
        head_mask_s         = '0;
        head_mask_s[head_q] = 1'b1;
    end

    wbb_match #(.DEPTH(DEPTH), .AW(AW)) u_coalesce (
        .valid_i  (coal_valid_s),
        .addr_i   (addr_q),
        .key_i    (bus.wb_addr),
        .newest_i (newest_s),
        .hit_o    (coal_hit_s),
        .idx_o    (coal_idx_s)
    );

    wbb_match #(.DEPTH(DEPTH), .AW(AW)) u_forward (
        .valid_i  (valid_q),
        .addr_i   (addr_q),
        .key_i    (bus.fetch_addr),
        .newest_i (newest_s),
        .hit_o    (fwd_hit_s),
        .idx_o    (fwd_idx_s)
    );

    // Next-state for pointers, valid bits and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        count_d = count_q;
        if (alloc_s) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        case (op_s)
            OP_PUSH: count_d = count_q + CW'(1);
            OP_POP:  count_d = count_q - CW'(1);
            OP_BOTH: count_d = count_q;
            OP_IDLE: count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards all buffered lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Line storage; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (push_s) begin
            if (coal_hit_s) begin
                data_q[coal_idx_s] <= bus.wb_data;
            end else begin
                addr_q[tail_q] <= bus.wb_addr;
                data_q[tail_q] <= bus.wb_data;
            end
        end
    end

    // Refill source: the eviction being accepted now beats anything stored.
    always_comb begin
        bus.fetch_data = bus.mem_read_data;
        if (push_s && (bus.wb_addr == bus.fetch_addr)) begin
            bus.fetch_data = bus.wb_data;
        end else if (fwd_hit_s) begin
            bus.fetch_data = data_q[fwd_idx_s];
        end else begin
            bus.fetch_data = bus.mem_read_data;
        end
    end

    assign bus.wb_ready  = wb_ready_s;
    assign bus.mem_raddr = bus.fetch_addr;
    assign bus.mem_wen   = (count_q != CW'(0));
    assign bus.mem_waddr = addr_q[head_q];
    assign bus.mem_wdata = data_q[head_q];
    assign bus.count     = count_q;

endmodule

// File: tb/tb_write_back_buffer.sv
// Scoreboard bench for write_back_buffer: a queue model of pending lines
// predicts occupancy, refill forwarding and the order of memory writes.
module tb_write_back_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int LW    = 256;

    typedef struct {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } ent_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    bit   chk_en;
    ent_t mq[$];

    write_back_buffer_if #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) bus ();

    write_back_buffer #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model at negedge, update model.
    task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [LW-1:0] d,
                       input logic [AW-1:0] f, input logic mr, input logic r,
                       output bit accepted);
        logic [LW-1:0] mrd;
        logic [LW-1:0] exp_fetch;
        bit            hit;
        mrd               = rnd_line();
        bus.wb_valid      = v;
        bus.wb_addr       = a;
        bus.wb_data       = d;
        bus.fetch_addr    = f;
        bus.mem_ready     = mr;
        bus.mem_read_data = mrd;
        rst               = r;
        @(negedge clk);
        exp_fetch = mrd;
        foreach (mq[i]) if (mq[i].a == f) exp_fetch = mq[i].d;
        if (v && mq.size() < DEPTH && a == f) exp_fetch = d;
        if (chk_en) begin
            chk("count", LW'(bus.count), LW'(mq.size()));
            chk("wb_ready", LW'(bus.wb_ready), LW'(mq.size() < DEPTH));
            chk("mem_wen", LW'(bus.mem_wen), LW'(mq.size() != 0));
            chk("mem_raddr", LW'(bus.mem_raddr), LW'(f));
            chk("fetch_data", bus.fetch_data, exp_fetch);
        end
        accepted = 1'b0;
        if (r) begin
            mq.delete();
            chk_en = 1'b1;
        end else if (v && mq.size() < DEPTH) begin
            accepted = 1'b1;
            hit = 1'b0;
            for (int i = mq.size() - 1; i >= 1; i--) begin
                if (!hit && mq[i].a == a) begin
                    mq[i].d = d;
                    hit = 1'b1;
                end
            end
            if (!hit) mq.push_back('{a: a, d: d});
        end
        @(posedge clk);
        #1;
    endtask

    // Memory-side monitor: every accepted write must match the oldest pending line.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (chk_en && rst === 1'b0 && bus.mem_wen === 1'b1 && bus.mem_ready === 1'b1) begin
                if (mq.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL spurious_write: got addr %h expected no write", bus.mem_waddr);
                end else begin
                    e = mq.pop_front();
                    chk("mem_waddr", LW'(bus.mem_waddr), LW'(e.a));
                    chk("mem_wdata", bus.mem_wdata, e.d);
                end
            end
        end
    end

    initial begin
        bit            acc;
        logic          cv;
        logic [AW-1:0] ca;
        logic [LW-1:0] cd;
        n_checks = 0;
        n_err    = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        bus.wb_valid = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        cyc(1'b0, '0, '0, 12'h000, 1'b0, 1'b1, acc);
        cyc(1'b0, '0, '0, 12'h000, 1'b0, 1'b1, acc);

        // Single line, held then drained.
        cyc(1'b1, 12'h010, rnd_line(), 12'h010, 1'b0, 1'b0, acc);
        cyc(1'b0, '0, '0, 12'h010, 1'b0, 1'b0, acc);
        cyc(1'b0, '0, '0, 12'h010, 1'b1, 1'b0, acc);
        cyc(1'b0, '0, '0, 12'h010, 1'b0, 1'b0, acc);

        // Fill, hold a fifth eviction across the full and the pop cycle.
        for (int i = 0; i < 4; i++) cyc(1'b1, 12'h100 + 12'(i), rnd_line(), 12'h101, 1'b0, 1'b0, acc);
        cd = rnd_line();
        cyc(1'b1, 12'h104, cd, 12'h104, 1'b0, 1'b0, acc);
        cyc(1'b1, 12'h104, cd, 12'h104, 1'b1, 1'b0, acc);
        cyc(1'b1, 12'h104, cd, 12'h104, 1'b0, 1'b0, acc);
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 12'h104, 1'b1, 1'b0, acc);

        // Coalesce onto a non-head line; a head match allocates.
        cyc(1'b1, 12'h020, rnd_line(), 12'h030, 1'b0, 1'b0, acc);
        cyc(1'b1, 12'h030, rnd_line(), 12'h030, 1'b0, 1'b0, acc);
        cyc(1'b1, 12'h030, rnd_line(), 12'h030, 1'b0, 1'b0, acc);
        cyc(1'b1, 12'h020, rnd_line(), 12'h020, 1'b0, 1'b0, acc);
        cyc(1'b0, '0, '0, 12'h020, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 12'h030, 1'b1, 1'b0, acc);

        // Forwarding from storage and from the eviction being accepted.
        cyc(1'b1, 12'h040, rnd_line(), 12'h041, 1'b0, 1'b0, acc);
        cyc(1'b0, '0, '0, 12'h040, 1'b0, 1'b0, acc);
        cyc(1'b1, 12'h050, rnd_line(), 12'h050, 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 12'h050, 1'b1, 1'b0, acc);

        // Streaming push with concurrent drain wraps both pointers.
        for (int i = 0; i < 10; i++) cyc(1'b1, (i % 2) ? 12'h210 : 12'h200, rnd_line(), 12'h200, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 12'h200, 1'b1, 1'b0, acc);

        // Reset with lines pending discards them.
        for (int i = 0; i < 3; i++) cyc(1'b1, 12'h300 + 12'(i), rnd_line(), 12'h300, 1'b0, 1'b0, acc);
        cyc(1'b0, '0, '0, 12'h300, 1'b0, 1'b1, acc);
        cyc(1'b0, '0, '0, 12'h300, 1'b0, 1'b0, acc);
        cyc(1'b0, '0, '0, 12'h301, 1'b1, 1'b0, acc);

        // Randomized traffic over a small address pool; a refused eviction is held.
        cv = 1'b0;
        ca = '0;
        cd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!cv || acc) begin
                cv = ($urandom_range(0, 9) < 7);
                ca = 12'h010 * 12'($urandom_range(1, 6));
                cd = rnd_line();
            end
            cyc(cv, ca, cd, 12'h010 * 12'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b0, acc);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, '0, 12'h010, 1'b1, 1'b0, acc);

        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/write_back_buffer.md
WRITE_BACK_BUFFER -- requirements
Module: write_back_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of line entries (power of two, 2..8).
REQ-002 The block SHALL have parameter AW, default 12, meaning the line address width.
REQ-003 The block SHALL have parameter LW, default 256, meaning the line data width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, as listed below.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wb_valid  in  1  the cache presents an evicted dirty line.
REQ-008 wb_addr  in  AW  line address of the eviction.
REQ-009 wb_data  in  LW  evicted line data.
REQ-010 wb_ready  out  1  the buffer can accept an eviction this cycle.
REQ-011 fetch_addr  in  AW  line address of the cache refill request.
REQ-012 fetch_data  out  LW  refill line returned to the cache.
REQ-013 mem_raddr  out  AW  data memory read address.
REQ-014 mem_read_data  in  LW  data memory read data.
REQ-015 mem_wen  out  1  data memory write request.
REQ-016 mem_ready  in  1  data memory accepts the write this cycle.
REQ-017 mem_waddr / mem_wdata  out  AW / LW  address and data of the head entry.
REQ-018 count  out  clog2(DEPTH)+1  number of valid entries.

Function
REQ-019 The block SHALL be a circular FIFO: head pointer, tail pointer, count, and a per-entry valid/addr/data store.
REQ-020 wb_ready SHALL equal (count < DEPTH), from registered state only; there is no same-cycle pop credit.
REQ-021 A push SHALL occur when wb_valid && wb_ready.
REQ-022 Coalesce: if wb_addr matches a valid non-head entry, that entry's data SHALL be overwritten, with no allocation and no change to count.
REQ-023 A match on the head entry only SHALL allocate a new tail entry, because the head may be draining.
REQ-024 mem_wen SHALL be (count != 0); mem_waddr and mem_wdata SHALL present the head entry combinationally.
REQ-025 A pop SHALL occur when mem_wen && mem_ready: head advances and the entry is invalidated.
REQ-026 On simultaneous push (allocating) and pop, count SHALL stay unchanged; push alone adds 1; pop alone subtracts 1.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 mem_raddr SHALL equal fetch_addr, combinationally.
REQ-029 fetch_data priority: (1) wb_data when wb_valid && wb_ready && wb_addr == fetch_addr; (2) the newest valid matching entry (closest to tail); (3) mem_read_data.
REQ-030 An entry popped in cycle N SHALL still forward in cycle N; from cycle N+1 the memory holds the data.
REQ-031 Zero-latency paths: fetch lookup and drain outputs are combinational from state; a pushed line is drainable from the next cycle.
REQ-032 When wb_valid is held with wb_ready low, the buffer SHALL drop nothing; the cache holds its request until wb_ready is high.

Reset
REQ-033 On rst, count, head and tail SHALL be 0 and all valid bits cleared, giving mem_wen=0 and wb_ready=1 in the cycle after reset.
REQ-034 Entry addr/data storage SHALL NOT be reset.
REQ-035 rst SHALL take priority over a simultaneous push or pop; buffered lines are discarded.

Structure
REQ-036 LINE_ASIZE (12) and LINE_DSIZE (256) SHALL be defined in the shared define.v and used as the AW/LW defaults.
REQ-037 One sub-module, wbb_match, SHALL hold the DEPTH-way address compare with newest-first priority select; the top-level block instantiates it twice, once for coalesce and once for forward.

Verification
REQ-038 Reset, then push 0x010/data A with mem_ready=0 -> count=1, mem_wen=1, mem_waddr=0x010; raise mem_ready -> pop next edge, count=0.
REQ-039 With mem_ready=0, push four distinct lines -> count=4, wb_ready=0; a fifth wb_valid is held; mem_ready=1 for one cycle -> wb_ready=1 the following cycle and the fifth line is accepted.
REQ-040 With mem_ready=0, buffer holds 0x020=A (head) and 0x030=B; push 0x030=C -> count stays 2 and memory later receives C; push 0x020=D -> count=3.
REQ-041 Buffer holds 0x040=E; fetch_addr=0x040 -> fetch_data=E, not mem_read_data; same cycle as push 0x050=F with fetch_addr=0x050 -> fetch_data=F.
REQ-042 With mem_ready=1 while pushing each cycle (alternating lines) -> count stays constant, pointers wrap past DEPTH-1, memory receives writes in order.
REQ-043 Assert rst with count=3 -> next cycle count=0, mem_wen=0, and fetch of a previously buffered address returns mem_read_data.
